// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU op codes,
// mux select encodings and the bundled control-word struct.
package ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ORR = 4'b0001;
    localparam logic [3:0] ALU_EOR = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b1011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] FUNCT_CMP = 4'b1010;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [3:0] alu_control;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic       instr_done;
    } ctrl_t;

    // Unlisted functs fall back to ADD so every encoding has a defined ALU op.
    function automatic logic [3:0] funct_to_alu(input logic [3:0] funct);
        case (funct)
            4'b0000: return ALU_AND;
            4'b0001: return ALU_EOR;
            4'b0010: return ALU_SUB;
            4'b0100: return ALU_ADD;
            4'b1100: return ALU_ORR;
            4'b1010: return ALU_SUB;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_logical(input logic [3:0] alu);
        return (alu == ALU_AND) || (alu == ALU_EOR) || (alu == ALU_ORR);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction/flag inputs and datapath control outputs of the controller.
interface multicycle_controller_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, IRWrite, RegWrite, MemWrite;
    logic        AdrSrc, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [3:0]  ALUControl;
    logic        InstrDone;

    modport master (
        output Instr, ALUFlags,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, InstrDone
    );

    modport slave (
        input  Instr, ALUFlags,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, InstrDone
    );
endinterface

// File: rtl/multicycle_controller_code_checker.sv
// ARM-style condition evaluator: decides whether cond holds for the given flags.
module code_checker (
    input  logic [3:0] cond_i,
    input  logic       n_i,
    input  logic       z_i,
    input  logic       c_i,
    input  logic       v_i,
    output logic       satisfied_o
);
    always_comb begin
        satisfied_o = 1'b0;
        case (cond_i)
            4'b0000: satisfied_o = z_i;
            4'b0001: satisfied_o = !z_i;
            4'b0010: satisfied_o = c_i;
            4'b0011: satisfied_o = !c_i;
            4'b0100: satisfied_o = n_i;
            4'b0101: satisfied_o = !n_i;
            4'b0110: satisfied_o = v_i;
            4'b0111: satisfied_o = !v_i;
            4'b1000: satisfied_o = c_i && !z_i;
            4'b1001: satisfied_o = !c_i || z_i;
            4'b1010: satisfied_o = (n_i == v_i);
            4'b1011: satisfied_o = (n_i != v_i);
            4'b1100: satisfied_o = !z_i && (n_i == v_i);
            4'b1101: satisfied_o = z_i || (n_i != v_i);
            default: satisfied_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control FSM: sequences fetch/decode/execute states and
// holds the NZCV flag register used for conditional execution.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.slave  bus
);
    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_q, cond_d;
    logic       cond_ex;
    ctrl_t      ctl;

    logic [3:0] cond, funct;
    logic [1:0] op;
    logic       imm_bit, s_bit, is_cmp;
    logic [3:0] alu_dp;
    logic       unused_instr;

    assign cond         = bus.Instr[31:28];
    assign op           = bus.Instr[27:26];
    assign imm_bit      = bus.Instr[25];
    assign funct        = bus.Instr[24:21];
    assign s_bit        = bus.Instr[20];
    assign unused_instr = ^bus.Instr[19:0];
    assign is_cmp       = (funct == FUNCT_CMP);
    assign alu_dp       = funct_to_alu(funct);

    code_checker u_code_checker (
        .cond_i      (cond),
        .n_i         (flags_q[3]),
        .z_i         (flags_q[2]),
        .c_i         (flags_q[1]),
        .v_i         (flags_q[0]),
        .satisfied_o (cond_ex)
    );

    always_comb begin
        ctl     = '0;
        state_d = state_q;
        flags_d = flags_q;
        cond_d  = cond_q;
        case (state_q)
            S_FETCH: begin
                ctl.ir_write    = 1'b1;
                ctl.alu_src_a   = 1'b1;
                ctl.alu_src_b   = SRCB_FOUR;
                ctl.alu_control = ALU_ADD;
                ctl.result_src  = RES_ALURESULT;
                ctl.pc_write    = 1'b1;
                state_d         = S_DECODE;
            end
            S_DECODE: begin
                ctl.alu_src_a   = 1'b1;
                ctl.alu_src_b   = SRCB_FOUR;
                ctl.alu_control = ALU_ADD;
                ctl.imm_src     = op;
                ctl.reg_src     = (op == OP_MEM) ? 2'b10 : (op == OP_BR) ? 2'b01 : 2'b00;
                case (op)
                    OP_DP:   state_d = imm_bit ? S_EXECI : S_EXECR;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    default: begin
                        ctl.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl.alu_src_b   = SRCB_EXTIMM;
                ctl.imm_src     = 2'b01;
                ctl.alu_control = ALU_ADD;
                state_d         = s_bit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                ctl.adr_src = 1'b1;
                state_d     = S_MEMWB;
            end
            S_MEMWB: begin
                ctl.result_src = RES_READDATA;
                ctl.reg_write  = cond_ex;
                ctl.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWRITE: begin
                ctl.adr_src    = 1'b1;
                ctl.mem_write  = cond_ex;
                ctl.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ctl.alu_src_b   = (state_q == S_EXECI) ? SRCB_EXTIMM : SRCB_RD2;
                ctl.alu_control = alu_dp;
                // Flags change on this edge, so latch the pass/fail for ALUWB now.
                cond_d          = cond_ex;
                if (cond_ex && (s_bit || is_cmp)) begin
                    if (is_logical(alu_dp)) flags_d[3:2] = bus.ALUFlags[3:2];
                    else                    flags_d      = bus.ALUFlags;
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                ctl.result_src = RES_ALUOUT;
                ctl.reg_write  = cond_q && !is_cmp;
                ctl.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_b   = SRCB_EXTIMM;
                ctl.imm_src     = 2'b10;
                ctl.reg_src     = 2'b01;
                ctl.alu_control = ALU_ADD;
                ctl.result_src  = RES_ALURESULT;
                ctl.pc_write    = cond_ex;
                ctl.instr_done  = 1'b1;
                state_d         = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (reset) begin
            state_d        = S_FETCH;
            flags_d        = 4'b0000;
            cond_d         = 1'b0;
            ctl.pc_write   = 1'b0;
            ctl.ir_write   = 1'b0;
            ctl.reg_write  = 1'b0;
            ctl.mem_write  = 1'b0;
            ctl.instr_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cond_q  <= cond_d;
        end
    end

    assign bus.PCWrite    = ctl.pc_write;
    assign bus.IRWrite    = ctl.ir_write;
    assign bus.RegWrite   = ctl.reg_write;
    assign bus.MemWrite   = ctl.mem_write;
    assign bus.AdrSrc     = ctl.adr_src;
    assign bus.ALUSrcA    = ctl.alu_src_a;
    assign bus.ALUSrcB    = ctl.alu_src_b;
    assign bus.ResultSrc  = ctl.result_src;
    assign bus.ALUControl = ctl.alu_control;
    assign bus.ImmSrc     = ctl.imm_src;
    assign bus.RegSrc     = ctl.reg_src;
    assign bus.InstrDone  = ctl.instr_done;
endmodule
